reg_writeback: RTL and testbench
================================

# reg_writeback

Register-file writeback stage, fed by the execute stage. The ALU stage produces up to two destination writes per instruction (two for `imul`: rax and rdx) plus a halt flag for `retq`. This block buffers those results in a small FIFO and commits them to the architectural 16×64 register file, one write per cycle. It exposes the register file and a pending-write mask back to decode and execute, so they can read operands and stall on hazards.

## Interface
Parameters:
- `NREGS`, 16, architectural registers; register i is numbered as in `RegMap` (rax=0, rdx=2).
- `WIDTH`, 64, register width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `wb_valid`  in  1  execute presents a result entry.
- `wb_ready`  out  1  entry accepted on an edge where `wb_valid && wb_ready`.
- `wb_en0`, `wb_dst0`, `wb_val0`  in  1/4/64  first write (enable, register number, value).
- `wb_en1`, `wb_dst1`, `wb_val1`  in  1/4/64  second write.
- `wb_halt`  in  1  entry is a halt (`retq`).
- `reg_file`  out  NREGS*WIDTH  flattened `logic[0:16*64-1]`; register i occupies bits [i*64 : i*64+63].
- `busy_mask`  out  NREGS  bit i set while any queued entry has an enabled write to register i.
- `retire`  out  1  one-cycle pulse after an entry is fully committed.
- `retire_count`  out  32  entries retired since reset; wraps at 2^32.
- `halted`  out  1  sticky; set when a halt entry retires.

## Operation
- **FIFO push.** An entry is pushed when `wb_valid && wb_ready`.
- **Ready.** `wb_ready = (count < DEPTH) && !halted`. Ready is combinational from registered state only; it does not depend on `wb_valid`.
- **Push/pop same edge, not full.** Both take effect; `count` is unchanged.
- **Push/pop same edge, full.** `wb_ready` stays 0; there is no pass-through.
- **Commit FSM.** Two states, `PH0` and `PH1`; it acts on the FIFO head only when the FIFO is non-empty.
  - `PH0`: write `val0` to `dst0` if `en0`.
    - If `en1`, go to `PH1`.
    - Otherwise pop the head and pulse `retire`; stay in `PH0`.
  - `PH1`: write `val1` to `dst1`; pop the head; pulse `retire`; return to `PH0`.
  - An entry with neither enable set, e.g. a pure halt, retires in one `PH0` cycle.
- **Same destination.** If `dst0 == dst1` with both enabled, the register ends with `val1`.
- **busy_mask.** OR, over all valid FIFO entries including the head in progress, of the one-hot `dst0` (if `en0`) and `dst1` (if `en1`).
  - In `PH1`, the head's `dst0` stays in the mask until the head pops.
- **Halt.** When a `wb_halt` entry retires, `halted` goes to 1 and `wb_ready` drops to 0 until reset. Entries queued behind the halt are impossible, because execute stops issuing after `retq`. If present, they are still committed.
- **retire_count.** Increments on each `retire`.

## Timing
- **Reset.** While `reset` is low at a rising edge:
  - `reg_file` = 0, FIFO emptied, FSM = `PH0`.
  - `busy_mask` = 0, `retire` = 0, `retire_count` = 0, `halted` = 0.
  - `wb_ready` is 1 from the first cycle after reset is released.
- **Reset mid-commit.** Reset overrides everything: it discards queued and partially committed entries. A `PH1` write scheduled for that edge is not performed.
- **Single-write latency.** Entry accepted at edge N, FIFO previously empty:
  - the write is performed at edge N+1;
  - the new value and `retire` are visible in the cycle after edge N+1;
  - `busy_mask` bit is set after edge N and cleared after edge N+1.
- **Dual-write latency.** `dst0` written at edge N+1, `dst1` at edge N+2; `retire` is asserted after N+2.
- **Throughput.** One single-write entry per cycle; one dual-write entry per two cycles.
- **Output timing.** All outputs come from registered state; no combinational input-to-output paths.

## Structure
- Add `wb_entry_t` to `DecoderTypes`: packed struct {`en0`, `dst0[3:0]`, `val0[63:0]`, `en1`, `dst1[3:0]`, `val1[63:0]`, `halt`}.
- Add the FSM state enum `wb_phase_t {PH0, PH1}` to the same package.
- Register numbering constants stay in `RegMap`.
- One sub-module, `wb_fifo`: synchronous FIFO parameterised on `DEPTH` with element type `wb_entry_t`. It exposes `push`, `pop`, `head`, `count`, and all-entries-valid/data vectors for the `busy_mask` OR-reduction.
- The top level holds the FSM, register array, counters and flattening.

## Test plan
- **Reset.** Hold `reset` low for 2 cycles, release → `reg_file` all 0, `wb_ready` = 1, `halted` = 0, `retire_count` = 0.
- **Single write.** Push {en0=1, dst0=3, val0=0xDEADBEEF_00000001} → register 3 = 0xDEADBEEF00000001 one edge after acceptance; `busy_mask[3]` high for exactly 1 cycle; `retire` pulses once.
- **imul-style dual write.** Push {dst0=0, val0=0x5, dst1=2, val1=0x7} → rax = 5 after edge N+1, rdx = 7 after edge N+2; `busy_mask` bits 0 and 2 held through N+2.
- **Back-pressure.** Push 8 dual-write entries back-to-back with DEPTH=4 → `wb_ready` drops once 4 are queued; all 8 commit in order; `retire_count` = 8; no entry lost or duplicated.
- **Same destination.** Push {en0=1, dst0=5, val0=1, en1=1, dst1=5, val1=2} → register 5 = 2.
- **Halt and mid-operation reset.** Push a halt entry → `halted` = 1, `wb_ready` = 0, held 10 cycles. Then queue 3 entries, assert `reset` during `PH1` → FIFO empty, `reg_file` = 0, the pending `dst1` write is not performed.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared types for the writeback stage.
//   RegMap       : architectural register numbers (rax=0, rdx=2, ...).
//   DecoderTypes : the writeback FIFO entry, the slim per-entry view used to
//                  build the pending-write mask, and the commit phase enum.
package RegMap;
  localparam logic [3:0] RAX = 4'd0;
  localparam logic [3:0] RCX = 4'd1;
  localparam logic [3:0] RDX = 4'd2;
  localparam logic [3:0] RBX = 4'd3;
  localparam logic [3:0] RSP = 4'd4;
  localparam logic [3:0] RBP = 4'd5;
  localparam logic [3:0] RSI = 4'd6;
  localparam logic [3:0] RDI = 4'd7;
  localparam logic [3:0] R8  = 4'd8;
  localparam logic [3:0] R9  = 4'd9;
  localparam logic [3:0] R10 = 4'd10;
  localparam logic [3:0] R11 = 4'd11;
  localparam logic [3:0] R12 = 4'd12;
  localparam logic [3:0] R13 = 4'd13;
  localparam logic [3:0] R14 = 4'd14;
  localparam logic [3:0] R15 = 4'd15;
endpackage

package DecoderTypes;
  typedef struct packed {
    logic        en0;
    logic [3:0]  dst0;
    logic [63:0] val0;
    logic        en1;
    logic [3:0]  dst1;
    logic [63:0] val1;
    logic        halt;
  } wb_entry_t;

  // Destination-only view of an entry; enough to build the busy mask.
  typedef struct packed {
    logic       en0;
    logic [3:0] dst0;
    logic       en1;
    logic [3:0] dst1;
  } wb_dst_t;

  typedef enum logic {PH0, PH1} wb_phase_t;
endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries.
//   clk, reset (sync, active-low)
//   push/din   : enqueue an entry (caller guarantees not full)
//   pop        : dequeue the head (caller guarantees not empty)
//   head       : oldest entry
//   count      : number of valid entries (0..DEPTH)
//   valid_vec  : per-slot valid bits
//   dst_vec    : per-slot destination view, for the pending-write mask
module wb_fifo
  import DecoderTypes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         valid_vec,
  output wb_dst_t [DEPTH-1:0]      dst_vec
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q]   = din;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      dst_vec[i].en0  = mem_q[i].en0;
      dst_vec[i].dst0 = mem_q[i].dst0;
      dst_vec[i].en1  = mem_q[i].en1;
      dst_vec[i].dst1 = mem_q[i].dst1;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign valid_vec = valid_q;
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: buffers execute-stage results and commits them to the
// architectural register file, one register write per cycle.
//   clk, reset (sync, active-low)
//   wb_valid/wb_ready      : entry handshake from execute
//   wb_en*/wb_dst*/wb_val* : up to two register writes per entry
//   wb_halt                : entry is a retq
//   reg_file               : flattened registers, reg i at [i*WIDTH +: WIDTH]
//   busy_mask              : registers with a queued, not yet retired write
//   retire/retire_count    : per-entry retire pulse and running count
//   halted                 : sticky, set when a halt entry retires
module reg_writeback
  import DecoderTypes::*;
#(
  parameter int NREGS = 16,
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic                     wb_en0,
  input  logic [3:0]               wb_dst0,
  input  logic [WIDTH-1:0]         wb_val0,
  input  logic                     wb_en1,
  input  logic [3:0]               wb_dst1,
  input  logic [WIDTH-1:0]         wb_val1,
  input  logic                     wb_halt,
  output logic [0:NREGS*WIDTH-1]   reg_file,
  output logic [NREGS-1:0]         busy_mask,
  output logic                     retire,
  output logic [31:0]              retire_count,
  output logic                     halted
);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t               fifo_din, head;
  logic [CW-1:0]           fifo_count;
  logic [DEPTH-1:0]        fifo_valid;
  wb_dst_t [DEPTH-1:0]     fifo_dst;
  logic                    push, pop;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  wb_phase_t        phase_q, phase_d;
  logic             retire_q, retire_d;
  logic [31:0]      retire_count_q, retire_count_d;
  logic             halted_q, halted_d;

  // Ready depends only on registered state, so a full FIFO never
  // passes an entry through even when the head pops on the same edge.
  assign wb_ready = (fifo_count != CW'(DEPTH)) && !halted_q;
  assign push     = wb_valid && wb_ready;

  assign fifo_din = '{en0: wb_en0, dst0: wb_dst0, val0: wb_val0,
                      en1: wb_en1, dst1: wb_dst1, val1: wb_val1,
                      halt: wb_halt};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (fifo_din),
    .head      (head),
    .count     (fifo_count),
    .valid_vec (fifo_valid),
    .dst_vec   (fifo_dst)
  );

  // Commit: PH0 performs write 0 and either retires the entry or moves to
  // PH1 for the second write; PH1 always retires. Halt is taken at retire.
  always_comb begin
    regs_d         = regs_q;
    phase_d        = phase_q;
    retire_d       = 1'b0;
    retire_count_d = retire_count_q;
    halted_d       = halted_q;
    pop            = 1'b0;
    if (fifo_count != '0) begin
      case (phase_q)
        PH0: begin
          if (head.en0) regs_d[head.dst0] = head.val0;
          if (head.en1) phase_d = PH1;
          else          pop     = 1'b1;
        end
        PH1: begin
          regs_d[head.dst1] = head.val1;
          pop               = 1'b1;
          phase_d           = PH0;
        end
        default: phase_d = PH0;
      endcase
    end
    if (pop) begin
      retire_d       = 1'b1;
      retire_count_d = retire_count_q + 32'd1;
      if (head.halt) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      phase_q        <= PH0;
      retire_q       <= 1'b0;
      retire_count_q <= '0;
      halted_q       <= 1'b0;
    end else begin
      regs_q         <= regs_d;
      phase_q        <= phase_d;
      retire_q       <= retire_d;
      retire_count_q <= retire_count_d;
      halted_q       <= halted_d;
    end
  end

  // The head stays in the FIFO through PH1, so its dst0 remains busy
  // until it pops.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) begin
        if (fifo_dst[i].en0) busy_mask[fifo_dst[i].dst0] = 1'b1;
        if (fifo_dst[i].en1) busy_mask[fifo_dst[i].dst1] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign reg_file[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign retire       = retire_q;
  assign retire_count = retire_count_q;
  assign halted       = halted_q;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed stimulus for reg_writeback, checked against a
// transaction-level model (queue of accepted entries applied in order on
// each retire) plus hand-computed literal expectations.
module tb_reg_writeback;
  import DecoderTypes::*;

  logic              clk;
  logic              reset;
  logic              wb_valid;
  logic              wb_ready;
  logic              wb_en0, wb_en1, wb_halt;
  logic [3:0]        wb_dst0, wb_dst1;
  logic [63:0]       wb_val0, wb_val1;
  logic [0:16*64-1]  reg_file;
  logic [15:0]       busy_mask;
  logic              retire;
  logic [31:0]       retire_count;
  logic              halted;

  int n_compared = 0;
  int n_failed   = 0;
  logic saw_not_ready = 1'b0;

  reg_writeback #(.NREGS(16), .WIDTH(64), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_en0       (wb_en0),
    .wb_dst0      (wb_dst0),
    .wb_val0      (wb_val0),
    .wb_en1       (wb_en1),
    .wb_dst1      (wb_dst1),
    .wb_val1      (wb_val1),
    .wb_halt      (wb_halt),
    .reg_file     (reg_file),
    .busy_mask    (busy_mask),
    .retire       (retire),
    .retire_count (retire_count),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare helper shared by the model monitor and the directed checks.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] getReg(input int i);
    return reg_file[i*64 +: 64];
  endfunction

  function automatic wb_entry_t mk(input logic en0, input logic [3:0] d0, input logic [63:0] v0,
                                   input logic en1, input logic [3:0] d1, input logic [63:0] v1,
                                   input logic h);
    wb_entry_t e;
    e.en0 = en0; e.dst0 = d0; e.val0 = v0;
    e.en1 = en1; e.dst1 = d1; e.val1 = v1;
    e.halt = h;
    return e;
  endfunction

  // Drive an entry (called just after a rising edge) and hold it until the
  // DUT accepts it; returns just after the accepting edge.
  task automatic applyStimulus(input wb_entry_t e);
    wb_valid = 1'b1;
    wb_en0 = e.en0; wb_dst0 = e.dst0; wb_val0 = e.val0;
    wb_en1 = e.en1; wb_dst1 = e.dst1; wb_val1 = e.val1;
    wb_halt = e.halt;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wb_ready) begin
        @(posedge clk); #1;
        return;
      end
      saw_not_ready = 1'b1;
      @(posedge clk); #1;
    end
    n_compared++;
    n_failed++;
    $display("[TB] FAIL accept_timeout: entry not accepted, expected acceptance within 100 cycles");
    wb_valid = 1'b0;
  endtask

  task automatic waitRetired(input int target);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (retire_count == 32'(target)) return;
    end
    n_compared++;
    n_failed++;
    $display("[TB] FAIL retire_timeout: retire_count=%0d, expected %0d", retire_count, target);
  endtask

  // ---------------- transaction-level model ----------------
  wb_entry_t   m_q[$];
  logic [63:0] m_regs[16];
  int          m_count;
  logic        m_halted;

  always @(negedge clk) begin
    wb_entry_t   e;
    logic [15:0] exp_busy;
    if (!reset) begin
      m_q.delete();
      for (int r = 0; r < 16; r++) m_regs[r] = '0;
      m_count  = 0;
      m_halted = 1'b0;
    end else begin
      if (retire) begin
        if (m_q.size() == 0) begin
          checkOutput("retire_without_entry", 64'(retire), 64'd0);
        end else begin
          e = m_q.pop_front();
          if (e.en0) m_regs[e.dst0] = e.val0;
          if (e.en1) m_regs[e.dst1] = e.val1;
          m_count++;
          if (e.halt) m_halted = 1'b1;
        end
      end
      exp_busy = '0;
      foreach (m_q[i]) begin
        if (m_q[i].en0) exp_busy[m_q[i].dst0] = 1'b1;
        if (m_q[i].en1) exp_busy[m_q[i].dst1] = 1'b1;
      end
      checkOutput("m_busy_mask", 64'(busy_mask), 64'(exp_busy));
      checkOutput("m_wb_ready", 64'(wb_ready), 64'((m_q.size() < 4) && !m_halted));
      checkOutput("m_halted", 64'(halted), 64'(m_halted));
      checkOutput("m_retire_count", 64'(retire_count), 64'(m_count));
      // Registers with pending writes may be mid-update; the rest must match.
      for (int r = 0; r < 16; r++)
        if (!exp_busy[r]) checkOutput($sformatf("m_reg%0d", r), getReg(r), m_regs[r]);
      if (wb_valid && wb_ready)
        m_q.push_back(mk(wb_en0, wb_dst0, wb_val0, wb_en1, wb_dst1, wb_val1, wb_halt));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    wb_valid = 1'b0;
    wb_en0 = 0; wb_dst0 = 0; wb_val0 = 0;
    wb_en1 = 0; wb_dst1 = 0; wb_val1 = 0;
    wb_halt = 0;

    // Reset for two edges.
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_reg_file_zero", 64'(reg_file == '0), 64'd1);
    checkOutput("rst_wb_ready", 64'(wb_ready), 64'd1);
    checkOutput("rst_halted", 64'(halted), 64'd0);
    checkOutput("rst_retire_count", 64'(retire_count), 64'd0);
    checkOutput("rst_busy_mask", 64'(busy_mask), 64'd0);

    // Single write to register 3.
    @(posedge clk); #1;
    applyStimulus(mk(1, 4'd3, 64'hDEADBEEF_00000001, 0, 0, 0, 0));
    wb_valid = 1'b0;
    @(negedge clk);
    checkOutput("single_busy_set", 64'(busy_mask), 64'h0008);
    checkOutput("single_reg3_before", getReg(3), 64'd0);
    @(negedge clk);
    checkOutput("single_reg3", getReg(3), 64'hDEADBEEF_00000001);
    checkOutput("single_retire", 64'(retire), 64'd1);
    checkOutput("single_busy_clear", 64'(busy_mask), 64'h0000);
    @(negedge clk);
    checkOutput("single_retire_once", 64'(retire), 64'd0);
    checkOutput("single_count", 64'(retire_count), 64'd1);

    // imul-style dual write: rax then rdx.
    @(posedge clk); #1;
    applyStimulus(mk(1, RegMap::RAX, 64'h5, 1, RegMap::RDX, 64'h7, 0));
    wb_valid = 1'b0;
    @(negedge clk);
    checkOutput("dual_busy_n", 64'(busy_mask), 64'h0005);
    @(negedge clk);
    checkOutput("dual_rax", getReg(0), 64'h5);
    checkOutput("dual_rdx_pending", getReg(2), 64'h0);
    checkOutput("dual_busy_n1", 64'(busy_mask), 64'h0005);
    checkOutput("dual_no_retire_yet", 64'(retire), 64'd0);
    @(negedge clk);
    checkOutput("dual_rdx", getReg(2), 64'h7);
    checkOutput("dual_busy_clear", 64'(busy_mask), 64'h0000);
    checkOutput("dual_retire", 64'(retire), 64'd1);
    checkOutput("dual_count", 64'(retire_count), 64'd2);

    // Back-pressure: 8 dual writes; dst1 is shared so its final value
    // reveals commit order.
    @(posedge clk); #1;
    saw_not_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      applyStimulus(mk(1, 4'(6 + i), 64'h100 + 64'(i), 1, 4'd14, 64'h200 + 64'(i), 0));
    wb_valid = 1'b0;
    waitRetired(10);
    checkOutput("bp_saw_not_ready", 64'(saw_not_ready), 64'd1);
    checkOutput("bp_count", 64'(retire_count), 64'd10);
    checkOutput("bp_r6", getReg(6), 64'h100);
    checkOutput("bp_r13", getReg(13), 64'h107);
    checkOutput("bp_r14_last", getReg(14), 64'h207);

    // Same destination: second write wins.
    @(posedge clk); #1;
    applyStimulus(mk(1, 4'd5, 64'h1, 1, 4'd5, 64'h2, 0));
    wb_valid = 1'b0;
    waitRetired(11);
    checkOutput("samedst_r5", getReg(5), 64'h2);

    // Halt entry with no writes.
    @(posedge clk); #1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1));
    wb_valid = 1'b0;
    waitRetired(12);
    checkOutput("halt_set", 64'(halted), 64'd1);
    checkOutput("halt_not_ready", 64'(wb_ready), 64'd0);
    repeat (10) @(negedge clk);
    checkOutput("halt_held", 64'(halted), 64'd1);
    checkOutput("halt_not_ready_held", 64'(wb_ready), 64'd0);
    checkOutput("halt_count", 64'(retire_count), 64'd12);

    // Reset clears the halt.
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst2_reg_file_zero", 64'(reg_file == '0), 64'd1);
    checkOutput("rst2_halted", 64'(halted), 64'd0);
    checkOutput("rst2_wb_ready", 64'(wb_ready), 64'd1);
    checkOutput("rst2_count", 64'(retire_count), 64'd0);

    // Queue entries, then reset on the edge where entry 1 would do its
    // PH1 write of r7.
    @(posedge clk); #1;
    applyStimulus(mk(1, 4'd1, 64'h11, 1, 4'd7, 64'h17, 0));
    applyStimulus(mk(1, 4'd8, 64'h28, 1, 4'd9, 64'h29, 0));
    wb_valid = 1'b1;
    wb_en0 = 1; wb_dst0 = 4'd10; wb_val0 = 64'h3A;
    wb_en1 = 1; wb_dst1 = 4'd11; wb_val1 = 64'h3B;
    wb_halt = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    wb_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_r7_not_written", getReg(7), 64'h0);
    checkOutput("midrst_r1_cleared", getReg(1), 64'h0);
    checkOutput("midrst_busy", 64'(busy_mask), 64'h0);
    checkOutput("midrst_retire", 64'(retire), 64'd0);
    checkOutput("midrst_ready", 64'(wb_ready), 64'd1);
    repeat (4) @(negedge clk);
    checkOutput("midrst_reg_file_zero", 64'(reg_file == '0), 64'd1);
    checkOutput("midrst_count", 64'(retire_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] global timeout");
  end
endmodule
